exe_div_iter: RTL and testbench

//  Parametrised iterative integer divider for the EXE stage (RV32M DIV/DIVU/REM/REMU).

---
 rtl/exe_div_iter.sv | 139 +++++++++++++
 tb/tb_exe_div_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_div_iter.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, BITS_PER_CYCLE quotient bits per cycle.
// Valid/ready on both sides; divide-by-zero and signed overflow take a one-cycle early-out path.
//
//   state | meaning
//   IDLE  | no operation held; ready to accept
//   BUSY  | iterating; cnt counts remaining iterations down to 0
//   DONE  | result presented on out_*, waiting for out_ready
module exe_div_iter #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int RD_WIDTH       = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_op,
   input  logic [XLEN-1:0]     in_rs1,
   input  logic [XLEN-1:0]     in_rs2,
   input  logic [RD_WIDTH-1:0] in_rd,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [RD_WIDTH-1:0] out_rd,
   output logic [XLEN-1:0]     out_result,
   output logic                busy
);

   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                state, state_nx;
   logic [CW-1:0]         cnt;
   logic [XLEN-1:0]       rem_q, quo_q, dsr_q;
   logic                  neg_q, neg_r, is_rem;
   logic [RD_WIDTH-1:0]   rd_q;

   logic                  accept, is_signed, a_neg, b_neg, div_zero, ovf, early;
   logic [XLEN-1:0]       mag_a, mag_b, early_res;
   logic [XLEN-1:0]       rem_nx, quo_nx, quo_fix, rem_fix, fin_res;

   assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   assign is_signed = !in_op[0];
   assign a_neg     = is_signed && in_rs1[XLEN-1];
   assign b_neg     = is_signed && in_rs2[XLEN-1];
   assign mag_a     = a_neg ? -in_rs1 : in_rs1;
   assign mag_b     = b_neg ? -in_rs2 : in_rs2;
   assign div_zero  = (in_rs2 == '0);
   assign ovf       = is_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
   assign early     = div_zero || ovf;

   always_comb begin
      early_res = in_op[1] ? in_rs1 : '1;
      if (!div_zero)
         early_res = in_op[1] ? '0 : in_rs1;
   end

   // Restoring steps: the quotient register doubles as the dividend shift register.
   always_comb begin
      logic [XLEN-1:0] r, q;
      logic [XLEN:0]   r_sh, diff;
      r = rem_q;
      q = quo_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         r_sh = {r, q[XLEN-1]};
         diff = r_sh - {1'b0, dsr_q};
         r    = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
         q    = {q[XLEN-2:0], ~diff[XLEN]};
      end
      rem_nx = r;
      quo_nx = q;
   end

   assign quo_fix = neg_q ? -quo_nx : quo_nx;
   assign rem_fix = neg_r ? -rem_nx : rem_nx;
   assign fin_res = is_rem ? rem_fix : quo_fix;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = early ? DONE : BUSY;
         BUSY:    if (cnt == '0) state_nx = DONE;
         DONE:    if (out_ready) state_nx = accept ? (early ? DONE : BUSY) : IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dsr_q      <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         is_rem     <= 1'b0;
         rd_q       <= '0;
         out_rd     <= '0;
         out_result <= '0;
      end else if (accept) begin
         cnt    <= CW'(N - 1);
         rem_q  <= '0;
         quo_q  <= mag_a;
         dsr_q  <= mag_b;
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         is_rem <= in_op[1];
         rd_q   <= in_rd;
         if (early) begin
            out_result <= early_res;
            out_rd     <= in_rd;
         end
      end else if (state == BUSY && !flush) begin
         rem_q <= rem_nx;
         quo_q <= quo_nx;
         cnt   <= cnt - CW'(1);
         if (cnt == '0) begin
            out_result <= fin_res;
            out_rd     <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_exe_div_iter.sv
// Directed bench for exe_div_iter: one instance at 1 bit/cycle and one at 2 bits/cycle share stimulus.
// Latency is counted in clock edges, the accepting edge being edge 1.
module tb_exe_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, out_ready;
   logic [1:0]  in_op;
   logic [31:0] in_rs1, in_rs2;
   logic [4:0]  in_rd;

   logic        in_ready1, out_valid1, busy1;
   logic [4:0]  out_rd1;
   logic [31:0] out_result1;
   logic        in_ready2, out_valid2, busy2;
   logic [4:0]  out_rd2;
   logic [31:0] out_result2;

   int n_asrt = 0;
   int n_fail = 0;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   always #5 clk = ~clk;

   exe_div_iter #(.XLEN(32), .BITS_PER_CYCLE(1), .RD_WIDTH(5)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush),
      .out_valid(out_valid1), .out_ready(out_ready), .out_rd(out_rd1),
      .out_result(out_result1), .busy(busy1)
   );

   exe_div_iter #(.XLEN(32), .BITS_PER_CYCLE(2), .RD_WIDTH(5)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush),
      .out_valid(out_valid2), .out_ready(out_ready), .out_rd(out_rd2),
      .out_result(out_result2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_rs1   = a;
      in_rs2   = b;
      in_rd    = rd;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_rs1   = 32'hDEAD_BEEF;
      in_rs2   = 32'h0000_0003;
      in_rd    = 5'd31;
   endtask

   // Starts #1 after the accepting edge; leaves both instances holding their result.
   task automatic wait_res(input string tag, input logic [31:0] exp, input logic [4:0] rd,
                           input int exp_lat1, input int exp_lat2);
      int k = 1;
      int lat1 = 0;
      int lat2 = 0;
      while (k <= 60 && (lat1 == 0 || lat2 == 0)) begin
         if (lat1 == 0 && out_valid1) lat1 = k;
         if (lat2 == 0 && out_valid2) lat2 = k;
         if (lat1 == 0 || lat2 == 0) begin
            @(posedge clk);
            #1;
            k++;
         end
      end
      chk({tag, "_lat1"}, 32'(lat1), 32'(exp_lat1));
      chk({tag, "_lat2"}, 32'(lat2), 32'(exp_lat2));
      chk({tag, "_res1"}, out_result1, exp);
      chk({tag, "_res2"}, out_result2, exp);
      chk({tag, "_rd1"}, 32'(out_rd1), 32'(rd));
      chk({tag, "_rd2"}, 32'(out_rd2), 32'(rd));
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_idle1"}, 32'(out_valid1), 32'd0);
      chk({tag, "_idle2"}, 32'(out_valid2), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input bit early_out);
      issue(op, a, b, rd);
      wait_res(tag, exp, rd, early_out ? 1 : 33, early_out ? 1 : 17);
      release_out(tag);
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      in_op     = 2'b00;
      in_rs1    = '0;
      in_rs2    = '0;
      in_rd     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {out_valid1, out_valid2, busy1, busy2}, 32'd0);
      chk("rst_result", out_result1 | out_result2, 32'd0);
      chk("rst_rd", 32'(out_rd1 | out_rd2), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_ready", {in_ready1, in_ready2}, 32'd3);

      run_op("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          5'd1,  32'd14,         1'b0);
      run_op("remu_100_7",   OP_REMU, 32'd100,        32'd7,          5'd2,  32'd2,          1'b0);
      run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  1'b0);
      run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  1'b0);
      run_op("rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd5,  32'd1,          1'b0);
      run_op("divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd6,  32'hFFFF_FFFF,  1'b0);
      run_op("divu_7_100",   OP_DIVU, 32'd7,          32'd100,        5'd7,  32'd0,          1'b0);
      run_op("divu_min_m1",  OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          1'b0);
      run_op("div_x_0",      OP_DIV,  32'd123,        32'd0,          5'd9,  32'hFFFF_FFFF,  1'b1);
      run_op("remu_5_0",     OP_REMU, 32'd5,          32'd0,          5'd10, 32'd5,          1'b1);
      run_op("div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  1'b1);
      run_op("rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          1'b1);

      // Backpressure: hold the result for 10 cycles while inputs wiggle.
      issue(OP_DIVU, 32'd100, 32'd7, 5'd13);
      wait_res("bp", 32'd14, 5'd13, 33, 17);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_rs1 = $urandom;
         in_rs2 = $urandom;
         in_rd  = 5'(i);
         #1;
         if (in_ready1 || in_ready2 || !out_valid1 || out_result1 !== 32'd14 || out_rd1 !== 5'd13
             || out_result2 !== 32'd14 || out_rd2 !== 5'd13)
            seen++;
      end
      chk("bp_hold", 32'(seen), 32'd0);

      // Handshake and new accept in the same cycle.
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = OP_REMU;
      in_rs1    = 32'd100;
      in_rs2    = 32'd7;
      in_rd     = 5'd14;
      #1;
      chk("b2b_ready", {in_ready1, in_ready2}, 32'd3);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_rs1    = 32'h1234_5678;
      chk("b2b_busy", {out_valid1, out_valid2, busy1, busy2}, 32'd3);
      wait_res("b2b", 32'd2, 5'd14, 33, 17);
      release_out("b2b");

      // Flush in the fifth BUSY cycle.
      issue(OP_DIVU, 32'd100, 32'd7, 5'd15);
      repeat (4) @(posedge clk);
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("flush_ready", {in_ready1, in_ready2}, 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_idle", {busy1, busy2, out_valid1, out_valid2}, 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid1 || out_valid2 || busy1 || busy2) seen++;
      end
      chk("flush_noval", 32'(seen), 32'd0);

      // Asynchronous reset in the middle of an operation.
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd16);
      repeat (3) @(posedge clk);
      #3;
      chk("pre_rst_busy", {busy1, busy2}, 32'd3);
      rst = 1'b1;
      #1;
      chk("arst_state", {busy1, busy2, out_valid1, out_valid2}, 32'd0);
      chk("arst_result", out_result1 | out_result2, 32'd0);
      chk("arst_rd", 32'(out_rd1 | out_rd2), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst", OP_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
